// File: rtl/pipe_control.sv
// Decode/issue stage: MIPS instruction -> registered execute control bundle (1 cycle).
// Holds when ExValid && !ExReady; a load-use bubble is inserted when PIPE_CONTROL_LOAD_STALL_EN is defined.
module pipe_control #(
  parameter int FUNC_W      = 6,
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   InstrValid,
  input  logic [31:0]            Instruction,
  output logic                   InstrReady,
  input  logic                   ExReady,
  input  logic                   Flush,
  output logic                   ExValid,
  output logic                   RegDst,
  output logic                   RegWriteEnable,
  output logic                   ALUSrc,
  output logic                   MemoryRE,
  output logic                   MemoryWE,
  output logic                   MemoryToReg,
  output logic [FUNC_W-1:0]      ALUFunction,
  output logic [REG_ADDR_W-1:0]  ExRs,
  output logic [REG_ADDR_W-1:0]  ExRt,
  output logic [REG_ADDR_W-1:0]  ExRd,
  output logic                   IllegalOp,
  output logic [STALL_CNT_W-1:0] StallCount
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  function automatic logic [FUNC_W-1:0] fit_fn(input logic [5:0] f);
    logic [FUNC_W+5:0] w;
    w = {{FUNC_W{1'b0}}, f};
    return w[FUNC_W-1:0];
  endfunction

  function automatic logic [REG_ADDR_W-1:0] fit_reg(input logic [4:0] r);
    logic [REG_ADDR_W+4:0] w;
    w = {{REG_ADDR_W{1'b0}}, r};
    return w[REG_ADDR_W-1:0];
  endfunction

  logic [5:0] opcode;
  logic       unused_shamt;
  assign opcode       = Instruction[31:26];
  assign unused_shamt = ^Instruction[10:6];

  logic       dec_legal, dec_regdst, dec_rwe, dec_alusrc, dec_re, dec_we, dec_m2r;
  logic [5:0] dec_fn;

  always_comb begin
    dec_legal  = 1'b1;
    dec_regdst = 1'b0;
    dec_rwe    = 1'b0;
    dec_alusrc = 1'b0;
    dec_re     = 1'b0;
    dec_we     = 1'b0;
    dec_m2r    = 1'b0;
    dec_fn     = 6'b000000;
    case (opcode)
      OP_RTYPE: begin dec_regdst = 1'b1; dec_rwe = 1'b1; dec_fn = Instruction[5:0]; end
      OP_ADDI:  begin dec_rwe = 1'b1; dec_alusrc = 1'b1; dec_fn = 6'b100000; end
      OP_SLTI:  begin dec_rwe = 1'b1; dec_alusrc = 1'b1; dec_fn = 6'b101010; end
      OP_ANDI:  begin dec_rwe = 1'b1; dec_alusrc = 1'b1; dec_fn = 6'b100100; end
      OP_ORI:   begin dec_rwe = 1'b1; dec_alusrc = 1'b1; dec_fn = 6'b100101; end
      OP_LW:    begin dec_rwe = 1'b1; dec_alusrc = 1'b1; dec_re = 1'b1; dec_m2r = 1'b1; dec_fn = 6'b100000; end
      OP_SW:    begin dec_alusrc = 1'b1; dec_we = 1'b1; dec_fn = 6'b100000; end
      default:  dec_legal = 1'b0;
    endcase
  end

  logic                  ex_valid_q, ex_valid_d;
  logic [5:0]            ctl_q, ctl_d;
  logic [FUNC_W-1:0]     fn_q, fn_d;
  logic [REG_ADDR_W-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic                  illegal_q, illegal_d;

  logic advance, hazard, accept;
  assign advance    = !ex_valid_q || ExReady;
  assign InstrReady = Reset && advance && !hazard && !Flush;
  assign accept     = InstrValid && InstrReady;

`ifdef PIPE_CONTROL_LOAD_STALL_EN
  // ctl_q[2] is the registered MemoryRE of the bundle in execute.
  logic rt_match;
  assign rt_match = (opcode == OP_RTYPE || opcode == OP_SW) && (rt_q == fit_reg(Instruction[20:16]));
  assign hazard   = InstrValid && ex_valid_q && ctl_q[2] && (rt_q != '0) &&
                    ((rt_q == fit_reg(Instruction[25:21])) || rt_match);

  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hazard && advance && !Flush && (stall_cnt_q != {STALL_CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end
  assign StallCount = stall_cnt_q;
`else
  assign hazard     = 1'b0;
  assign StallCount = '0;
`endif

  always_comb begin
    ex_valid_d = ex_valid_q;
    ctl_d      = ctl_q;
    fn_d       = fn_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    rd_d       = rd_q;
    illegal_d  = 1'b0;
    if (Flush || (advance && !accept)) begin
      ex_valid_d = 1'b0;
      ctl_d      = '0;
      fn_d       = '0;
      rs_d       = '0;
      rt_d       = '0;
      rd_d       = '0;
    end else if (accept) begin
      ex_valid_d = 1'b1;
      ctl_d      = {dec_regdst, dec_rwe, dec_alusrc, dec_re, dec_we, dec_m2r};
      fn_d       = fit_fn(dec_fn);
      rs_d       = fit_reg(Instruction[25:21]);
      rt_d       = fit_reg(Instruction[20:16]);
      rd_d       = fit_reg(Instruction[15:11]);
      illegal_d  = !dec_legal;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      ex_valid_q <= 1'b0;
      ctl_q      <= '0;
      fn_q       <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      illegal_q  <= 1'b0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ctl_q      <= ctl_d;
      fn_q       <= fn_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rd_q       <= rd_d;
      illegal_q  <= illegal_d;
    end
  end

  assign ExValid        = ex_valid_q;
  assign RegDst         = ctl_q[5];
  assign RegWriteEnable = ctl_q[4];
  assign ALUSrc         = ctl_q[3];
  assign MemoryRE       = ctl_q[2];
  assign MemoryWE       = ctl_q[1];
  assign MemoryToReg    = ctl_q[0];
  assign ALUFunction    = fn_q;
  assign ExRs           = rs_q;
  assign ExRt           = rt_q;
  assign ExRd           = rd_q;
  assign IllegalOp      = illegal_q;

endmodule

// File: tb/tb_pipe_control.sv
// Directed + randomized bench for pipe_control against a behavioural issue-stage model.
module tb_pipe_control;
  localparam int CW = 3;

  logic          Clock = 1'b0;
  logic          Reset, InstrValid, ExReady, Flush;
  logic [31:0]   Instruction;
  logic          InstrReady, ExValid, RegDst, RegWriteEnable, ALUSrc;
  logic          MemoryRE, MemoryWE, MemoryToReg, IllegalOp;
  logic [5:0]    ALUFunction;
  logic [4:0]    ExRs, ExRt, ExRd;
  logic [CW-1:0] StallCount;

  pipe_control #(.FUNC_W(6), .REG_ADDR_W(5), .STALL_CNT_W(CW)) dut (
    .Clock(Clock), .Reset(Reset), .InstrValid(InstrValid), .Instruction(Instruction),
    .InstrReady(InstrReady), .ExReady(ExReady), .Flush(Flush), .ExValid(ExValid),
    .RegDst(RegDst), .RegWriteEnable(RegWriteEnable), .ALUSrc(ALUSrc),
    .MemoryRE(MemoryRE), .MemoryWE(MemoryWE), .MemoryToReg(MemoryToReg),
    .ALUFunction(ALUFunction), .ExRs(ExRs), .ExRt(ExRt), .ExRd(ExRd),
    .IllegalOp(IllegalOp), .StallCount(StallCount)
  );

  always #5 Clock = ~Clock;

`ifdef PIPE_CONTROL_LOAD_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Expected state of the execute-facing bundle.
  bit       m_vld, m_ill;
  bit       m_regdst, m_rwe, m_alusrc, m_re, m_we, m_m2r;
  bit [5:0] m_fn;
  bit [4:0] m_rs, m_rt, m_rd;
  int       m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_vld = 0; m_ill = 0; m_regdst = 0; m_rwe = 0; m_alusrc = 0;
    m_re = 0; m_we = 0; m_m2r = 0; m_fn = 0; m_rs = 0; m_rt = 0; m_rd = 0; m_cnt = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ExValid"},   ExValid, m_vld);
    chk({tag, ".RegDst"},    RegDst, m_regdst);
    chk({tag, ".RegWE"},     RegWriteEnable, m_rwe);
    chk({tag, ".ALUSrc"},    ALUSrc, m_alusrc);
    chk({tag, ".MemRE"},     MemoryRE, m_re);
    chk({tag, ".MemWE"},     MemoryWE, m_we);
    chk({tag, ".MemToReg"},  MemoryToReg, m_m2r);
    chk({tag, ".ALUFunc"},   ALUFunction, m_fn);
    chk({tag, ".Regs"},      {ExRs, ExRt, ExRd}, {m_rs, m_rt, m_rd});
    chk({tag, ".IllegalOp"}, IllegalOp, m_ill);
    chk({tag, ".StallCnt"},  StallCount, m_cnt);
  endtask

  // One clock of stimulus: checks InstrReady combinationally, advances the model, checks the bundle.
  task automatic apply(input string tag, input bit v, input logic [31:0] ins, input bit er, input bit fl);
    bit [5:0] op;
    bit       adv, haz, rdy, uses_rt, legal;
    InstrValid = v; Instruction = ins; ExReady = er; Flush = fl;
    #1;
    op      = ins[31:26];
    uses_rt = (op == 6'h00) || (op == 6'h2b);
    adv     = !m_vld || er;
    haz     = STALL_EN && v && m_vld && m_re && (m_rt != 0) &&
              ((m_rt == ins[25:21]) || (uses_rt && m_rt == ins[20:16]));
    rdy     = adv && !haz && !fl;
    chk({tag, ".InstrReady"}, InstrReady, rdy);
    if (haz && adv && !fl && m_cnt < (1 << CW) - 1) m_cnt++;
    m_ill = 0;
    if (fl || (adv && !(v && rdy))) begin
      m_vld = 0; {m_regdst, m_rwe, m_alusrc, m_re, m_we, m_m2r} = 6'b0;
      m_fn = 0; m_rs = 0; m_rt = 0; m_rd = 0;
    end else if (adv) begin
      legal = 1;
      {m_regdst, m_rwe, m_alusrc, m_re, m_we, m_m2r} = 6'b0;
      m_fn = 0;
      case (op)
        6'h00: begin m_regdst = 1; m_rwe = 1; m_fn = ins[5:0]; end
        6'h08: begin m_rwe = 1; m_alusrc = 1; m_fn = 6'h20; end
        6'h0a: begin m_rwe = 1; m_alusrc = 1; m_fn = 6'h2a; end
        6'h0c: begin m_rwe = 1; m_alusrc = 1; m_fn = 6'h24; end
        6'h0d: begin m_rwe = 1; m_alusrc = 1; m_fn = 6'h25; end
        6'h23: begin m_rwe = 1; m_alusrc = 1; m_re = 1; m_m2r = 1; m_fn = 6'h20; end
        6'h2b: begin m_alusrc = 1; m_we = 1; m_fn = 6'h20; end
        default: legal = 0;
      endcase
      m_vld = 1; m_ill = !legal;
      m_rs = ins[25:21]; m_rt = ins[20:16]; m_rd = ins[15:11];
    end
    @(posedge Clock); #1;
    check_all(tag);
  endtask

  localparam logic [31:0] ADD_10_8_9  = 32'h0109_5020;
  localparam logic [31:0] LW_9_8      = 32'h8D09_0000;
  localparam logic [31:0] ADD_10_9_11 = 32'h012B_5020;
  localparam logic [31:0] LW_0_8      = 32'h8D00_0000;
  localparam logic [31:0] ADD_10_0_11 = 32'h000B_5020;
  localparam logic [31:0] SW_9_8      = 32'hAD09_0004;
  localparam logic [31:0] ADDI_3_2    = 32'h2043_0007;
  localparam logic [31:0] ILLEGAL     = 32'hFC00_0000;

  bit [5:0] ops [9] = '{6'h00, 6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h23, 6'h2b, 6'h3f, 6'h04};

  initial begin
    model_reset();
    Reset = 0; InstrValid = 1; Instruction = ADD_10_8_9; ExReady = 1; Flush = 0;
    #2;
    chk("reset.InstrReady", InstrReady, 1'b0);
    check_all("reset");
    repeat (2) @(posedge Clock);
    @(negedge Clock); Reset = 1; InstrValid = 0;
    @(posedge Clock); #1;
    check_all("post_reset");

    apply("add", 1, ADD_10_8_9, 1, 0);
    chk("add.spec", {ExValid, RegDst, ALUFunction, ExRd}, {1'b1, 1'b1, 6'b100000, 5'd10});

    apply("lw9", 1, LW_9_8, 1, 0);
    apply("add_dep", 1, ADD_10_9_11, 1, 0);
    chk("add_dep.bubble", ExValid, !STALL_EN);
    apply("add_dep2", 1, ADD_10_9_11, 1, 0);
    chk("add_dep2.count", StallCount, STALL_EN ? 1 : 0);

    apply("lw0", 1, LW_0_8, 1, 0);
    apply("add_r0", 1, ADD_10_0_11, 1, 0);
    chk("add_r0.count", StallCount, STALL_EN ? 1 : 0);

    apply("sw", 1, SW_9_8, 1, 0);
    for (int i = 0; i < 3; i++) apply("sw_hold", 1, ADDI_3_2, 0, 0);
    chk("sw_hold.bundle", {ExValid, MemoryWE, ALUSrc}, 3'b111);
    apply("sw_release", 1, ADDI_3_2, 1, 0);

    apply("illegal", 1, ILLEGAL, 1, 0);
    chk("illegal.spec", {IllegalOp, ExValid, RegWriteEnable, MemoryWE, ALUFunction}, {1'b1, 1'b1, 8'h00});
    apply("after_illegal", 1, ADDI_3_2, 1, 0);

    apply("flush", 1, ADD_10_8_9, 1, 1);
    apply("flush_stalled", 1, ADD_10_8_9, 0, 1);

    // Repeated load-use pairs drive the narrow counter into saturation.
    for (int i = 0; i < 8; i++) begin
      apply("sat_lw", 1, LW_9_8, 1, 0);
      apply("sat_add", 1, ADD_10_9_11, 1, 0);
    end
    chk("sat.count", StallCount, STALL_EN ? (1 << CW) - 1 : 0);

    apply("mid_load", 1, LW_9_8, 0, 0);
    Reset = 0; InstrValid = 0;
    #2;
    model_reset();
    chk("midreset.InstrReady", InstrReady, 1'b0);
    check_all("midreset");
    @(negedge Clock); Reset = 1;
    @(posedge Clock); #1;
    check_all("after_midreset");

    for (int i = 0; i < 400; i++) begin
      logic [31:0] ins;
      ins = {ops[$urandom_range(0, 8)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 5'($urandom), 6'($urandom)};
      apply("rand", ($urandom_range(0, 9) < 8), ins, ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 19) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
